// File: rtl/id_issue_stage.sv
// Decode/issue stage between IF and EX: a single output register with valid/ready on both sides,
// and a per-register in-flight write counter that stalls issue on RAW hazards.
module id_issue_stage #(
   parameter int ADDR_WIDTH   = 5,
   parameter int MAX_INFLIGHT = 3,
   parameter int XLEN         = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic                  if_valid_i,
   output logic                  if_ready_o,
   input  logic [XLEN-1:0]       instr_i,
   input  logic [XLEN-1:0]       pc_i,
   input  logic                  rs1_used_i,
   input  logic                  rs2_used_i,
   input  logic                  rd_we_i,
   output logic                  ex_valid_o,
   input  logic                  ex_ready_i,
   output logic [XLEN-1:0]       ex_instr_o,
   output logic [XLEN-1:0]       ex_pc_o,
   output logic                  ex_rd_we_o,
   input  logic                  rel_valid_i,
   input  logic [ADDR_WIDTH-1:0] rel_addr_i,
   output logic                  busy_o,
   output logic                  sb_err_o
);

   localparam int NUM_REGS = 2 ** ADDR_WIDTH;
   localparam int CW       = $clog2(MAX_INFLIGHT + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);

   logic [ADDR_WIDTH-1:0] rs1, rs2, rd, ex_rd;
   logic [CW-1:0]         cnt_q [NUM_REGS];
   logic [CW-1:0]         cnt_d [NUM_REGS];
   logic                  ex_valid_q, ex_rd_we_q, sb_err_q;
   logic [XLEN-1:0]       ex_instr_q, ex_pc_q;
   logic                  hazard, sat, space, accept, kill, err_set, busy;

   assign rs1   = instr_i[15 +: ADDR_WIDTH];
   assign rs2   = instr_i[20 +: ADDR_WIDTH];
   assign rd    = instr_i[7 +: ADDR_WIDTH];
   assign ex_rd = ex_instr_q[7 +: ADDR_WIDTH];

   // Handshake: a transfer happens on a rising edge where valid and ready are both high.
   // if_ready_o is combinational and never depends on if_valid_i; ex_valid_o, once high,
   // holds with stable payload until ex_ready_i or flush_i. Hazards use pre-update counters.
   assign hazard = (rs1_used_i && (rs1 != '0) && (cnt_q[rs1] != '0)) ||
                   (rs2_used_i && (rs2 != '0) && (cnt_q[rs2] != '0));
   assign sat    = rd_we_i && (rd != '0) && (cnt_q[rd] == CNT_MAX);
   assign space  = ~ex_valid_q | ex_ready_i;

   assign if_ready_o = ~flush_i & ~hazard & ~sat & space;
   assign accept     = if_valid_i & if_ready_o;
   assign kill       = flush_i & ex_valid_q & ex_rd_we_q & (ex_rd != '0);

   // Increment first so an issue and a release of the same register cancel out;
   // each decrement then saturates at zero independently and flags the underflow.
   always_comb begin
      err_set = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (i != 0) begin
            if (accept && rd_we_i && (rd == ADDR_WIDTH'(i))) begin
               cnt_d[i] = cnt_d[i] + CW'(1);
            end
            if (rel_valid_i && (rel_addr_i == ADDR_WIDTH'(i))) begin
               if (cnt_d[i] == '0) err_set = 1'b1;
               else                cnt_d[i] = cnt_d[i] - CW'(1);
            end
            if (kill && (ex_rd == ADDR_WIDTH'(i))) begin
               if (cnt_d[i] == '0) err_set = 1'b1;
               else                cnt_d[i] = cnt_d[i] - CW'(1);
            end
         end
      end
   end

   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         busy = busy | (cnt_q[i] != '0);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= '0;
         sb_err_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) cnt_q[i] <= cnt_d[i];
         sb_err_q <= sb_err_q | err_set;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ex_valid_q <= 1'b0;
         ex_instr_q <= '0;
         ex_pc_q    <= '0;
         ex_rd_we_q <= 1'b0;
      end else if (flush_i) begin
         ex_valid_q <= 1'b0;
      end else if (accept) begin
         ex_valid_q <= 1'b1;
         ex_instr_q <= instr_i;
         ex_pc_q    <= pc_i;
         ex_rd_we_q <= rd_we_i;
      end else if (ex_ready_i) begin
         ex_valid_q <= 1'b0;
      end
   end

   assign ex_valid_o = ex_valid_q;
   assign ex_instr_o = ex_instr_q;
   assign ex_pc_o    = ex_pc_q;
   assign ex_rd_we_o = ex_rd_we_q;
   assign busy_o     = busy;
   assign sb_err_o   = sb_err_q;

endmodule

// File: tb/tb_id_issue_stage.sv
// Bench for id_issue_stage: directed scenarios then random traffic, checked every cycle
// against a register-count model of the issue rules.
module tb_id_issue_stage;

   localparam int AW = 5;
   localparam int MI = 3;
   localparam int XL = 32;
   localparam int NR = 32;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          flush_i = 1'b0;
   logic          if_valid_i = 1'b0;
   logic          if_ready_o;
   logic [XL-1:0] instr_i = '0;
   logic [XL-1:0] pc_i = '0;
   logic          rs1_used_i = 1'b0;
   logic          rs2_used_i = 1'b0;
   logic          rd_we_i = 1'b0;
   logic          ex_valid_o;
   logic          ex_ready_i = 1'b1;
   logic [XL-1:0] ex_instr_o;
   logic [XL-1:0] ex_pc_o;
   logic          ex_rd_we_o;
   logic          rel_valid_i = 1'b0;
   logic [AW-1:0] rel_addr_i = '0;
   logic          busy_o;
   logic          sb_err_o;

   always #5 clk_i = ~clk_i;

   id_issue_stage #(.ADDR_WIDTH(AW), .MAX_INFLIGHT(MI), .XLEN(XL)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .if_valid_i(if_valid_i), .if_ready_o(if_ready_o),
      .instr_i(instr_i), .pc_i(pc_i),
      .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i), .rd_we_i(rd_we_i),
      .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
      .ex_instr_o(ex_instr_o), .ex_pc_o(ex_pc_o), .ex_rd_we_o(ex_rd_we_o),
      .rel_valid_i(rel_valid_i), .rel_addr_i(rel_addr_i),
      .busy_o(busy_o), .sb_err_o(sb_err_o)
   );

   int checks = 0;
   int errors = 0;

   // model: pending-write count per register plus the instruction sitting in the stage
   int            cnt_m [NR];
   bit            m_valid, m_rd_we, m_err;
   logic [XL-1:0] m_instr, m_pc;

   function automatic logic [XL-1:0] mk(input int rd, input int rs1, input int rs2);
      logic [XL-1:0] v;
      v        = '0;
      v[6:0]   = 7'h33;
      v[11:7]  = rd[4:0];
      v[19:15] = rs1[4:0];
      v[24:20] = rs2[4:0];
      return v;
   endfunction

   task automatic reset_model();
      foreach (cnt_m[i]) cnt_m[i] = 0;
      m_valid = 0; m_rd_we = 0; m_err = 0;
      m_instr = '0; m_pc = '0;
   endtask

   function automatic bit model_ready();
      int r1, r2, rd;
      bit hz, st;
      r1 = int'(instr_i[19:15]);
      r2 = int'(instr_i[24:20]);
      rd = int'(instr_i[11:7]);
      hz = (rs1_used_i && r1 != 0 && cnt_m[r1] > 0) || (rs2_used_i && r2 != 0 && cnt_m[r2] > 0);
      st = rd_we_i && rd != 0 && cnt_m[rd] >= MI;
      return !flush_i && !hz && !st && (!m_valid || ex_ready_i);
   endfunction

   function automatic bit model_busy();
      foreach (cnt_m[i]) if (cnt_m[i] > 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_dec(input int a);
      if (cnt_m[a] == 0) m_err = 1;
      else               cnt_m[a]--;
   endtask

   task automatic check(input string tag, input logic [XL-1:0] obs, input logic [XL-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Compare all outputs mid-cycle, then advance the model across the rising edge.
   task automatic cycle();
      bit acc, n_valid, n_rd_we, do_kill, do_rel;
      int inc_r, rel_r, kill_r;
      logic [XL-1:0] n_instr, n_pc;
      @(negedge clk_i);
      check("if_ready",   {31'b0, if_ready_o}, {31'b0, model_ready()});
      check("ex_valid",   {31'b0, ex_valid_o}, {31'b0, m_valid});
      check("ex_instr",   ex_instr_o, m_instr);
      check("ex_pc",      ex_pc_o, m_pc);
      check("ex_rd_we",   {31'b0, ex_rd_we_o}, {31'b0, m_rd_we});
      check("busy",       {31'b0, busy_o}, {31'b0, model_busy()});
      check("sb_err",     {31'b0, sb_err_o}, {31'b0, m_err});
      acc     = if_valid_i && model_ready();
      n_valid = m_valid; n_instr = m_instr; n_pc = m_pc; n_rd_we = m_rd_we;
      if (flush_i) n_valid = 0;
      else if (acc) begin
         n_valid = 1; n_instr = instr_i; n_pc = pc_i; n_rd_we = rd_we_i;
      end else if (ex_ready_i) n_valid = 0;
      inc_r   = (acc && rd_we_i) ? int'(instr_i[11:7]) : 0;
      do_rel  = rel_valid_i && rel_addr_i != 0;
      rel_r   = int'(rel_addr_i);
      kill_r  = int'(m_instr[11:7]);
      do_kill = flush_i && m_valid && m_rd_we && kill_r != 0;
      @(posedge clk_i);
      #1;
      if (inc_r != 0) cnt_m[inc_r]++;
      if (do_rel)  model_dec(rel_r);
      if (do_kill) model_dec(kill_r);
      m_valid = n_valid; m_instr = n_instr; m_pc = n_pc; m_rd_we = n_rd_we;
   endtask

   task automatic idle();
      if_valid_i = 0; flush_i = 0; rel_valid_i = 0; rel_addr_i = '0;
      ex_ready_i = 1; rs1_used_i = 0; rs2_used_i = 0; rd_we_i = 0;
   endtask

   task automatic issue(input logic [XL-1:0] ins, input logic [XL-1:0] pc,
                        input bit u1, input bit u2, input bit we);
      if_valid_i = 1; instr_i = ins; pc_i = pc;
      rs1_used_i = u1; rs2_used_i = u2; rd_we_i = we;
   endtask

   task automatic release_reg(input int r);
      rel_valid_i = 1; rel_addr_i = r[AW-1:0];
   endtask

   initial begin
      reset_model();
      idle();
      rst_ni = 0;
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_ex_valid", {31'b0, ex_valid_o}, 32'd0);
      check("rst_ex_instr", ex_instr_o, 32'd0);
      check("rst_ex_pc",    ex_pc_o, 32'd0);
      check("rst_ex_rd_we", {31'b0, ex_rd_we_o}, 32'd0);
      check("rst_busy",     {31'b0, busy_o}, 32'd0);
      check("rst_sb_err",   {31'b0, sb_err_o}, 32'd0);
      rst_ni = 1;

      // independent stream issues back to back
      issue(mk(1, 2, 3), 32'h100, 1, 1, 1);
      #1 check("indep_rdy0", {31'b0, if_ready_o}, 32'd1);
      cycle();
      issue(mk(4, 5, 6), 32'h104, 1, 1, 1);
      #1 check("indep_rdy1", {31'b0, if_ready_o}, 32'd1);
      cycle();
      idle();
      #1 check("indep_pc1", ex_pc_o, 32'h104);
      cycle();
      #1 check("indep_drain", {31'b0, ex_valid_o}, 32'd0);
      release_reg(1); cycle();
      release_reg(4); cycle();
      idle();
      #1 check("indep_busy0", {31'b0, busy_o}, 32'd0);

      // RAW on x5: stall until the cycle after the release
      issue(mk(5, 1, 2), 32'h110, 1, 1, 1);
      cycle();
      issue(mk(8, 5, 0), 32'h114, 1, 0, 1);
      for (int c = 1; c <= 3; c++) begin
         #1 check("raw_stall", {31'b0, if_ready_o}, 32'd0);
         cycle();
      end
      release_reg(5);
      #1 check("raw_no_bypass", {31'b0, if_ready_o}, 32'd0);
      cycle();
      rel_valid_i = 0;
      #1 check("raw_rdy5", {31'b0, if_ready_o}, 32'd1);
      check("raw_busy5", {31'b0, busy_o}, 32'd0);
      cycle();
      idle(); release_reg(8); cycle();
      idle();

      // x0 is never tracked
      issue(mk(0, 3, 4), 32'h120, 1, 1, 1);
      cycle();
      issue(mk(6, 0, 0), 32'h124, 1, 1, 0);
      #1 check("x0_no_stall", {31'b0, if_ready_o}, 32'd1);
      cycle();
      idle(); cycle();
      #1 check("x0_busy", {31'b0, busy_o}, 32'd0);

      // backpressure holds payload stable
      issue(mk(10, 1, 2), 32'h200, 1, 1, 0);
      cycle();
      issue(mk(11, 3, 4), 32'h204, 1, 1, 0);
      ex_ready_i = 0;
      for (int c = 0; c < 3; c++) begin
         #1 check("bp_rdy", {31'b0, if_ready_o}, 32'd0);
         check("bp_pc", ex_pc_o, 32'h200);
         check("bp_instr", ex_instr_o, mk(10, 1, 2));
         cycle();
      end
      ex_ready_i = 1;
      #1 check("bp_release_rdy", {31'b0, if_ready_o}, 32'd1);
      cycle();
      #1 check("bp_next_pc", ex_pc_o, 32'h204);
      idle(); cycle();

      // saturation on x7
      for (int c = 0; c < 3; c++) begin
         issue(mk(7, 0, 0), 32'h300 + 4 * c, 0, 0, 1);
         #1 check("sat_accept", {31'b0, if_ready_o}, 32'd1);
         cycle();
      end
      issue(mk(7, 0, 0), 32'h30c, 0, 0, 1);
      #1 check("sat_stall", {31'b0, if_ready_o}, 32'd0);
      cycle();
      release_reg(7);
      cycle();
      rel_valid_i = 0;
      #1 check("sat_after_rel", {31'b0, if_ready_o}, 32'd1);
      cycle();
      issue(mk(7, 0, 0), 32'h310, 0, 0, 1);
      #1 check("sat_full_again", {31'b0, if_ready_o}, 32'd0);
      idle();
      for (int c = 0; c < 3; c++) begin
         release_reg(7); cycle();
      end
      idle();
      #1 check("sat_busy0", {31'b0, busy_o}, 32'd0);

      // flush kills held write to x9 together with an external release
      issue(mk(9, 0, 0), 32'h400, 0, 0, 1);
      cycle();
      issue(mk(9, 0, 0), 32'h404, 0, 0, 1);
      cycle();
      idle();
      ex_ready_i = 0; flush_i = 1; release_reg(9);
      cycle();
      idle();
      #1 check("flush_valid", {31'b0, ex_valid_o}, 32'd0);
      check("flush_busy", {31'b0, busy_o}, 32'd0);
      check("flush_err0", {31'b0, sb_err_o}, 32'd0);
      release_reg(9); cycle();
      idle();
      #1 check("flush_err1", {31'b0, sb_err_o}, 32'd1);

      // reset mid-stall
      issue(mk(12, 0, 0), 32'h500, 0, 0, 1);
      cycle();
      ex_ready_i = 0; if_valid_i = 0;
      cycle();
      #2 rst_ni = 0;
      #1;
      check("mid_rst_valid", {31'b0, ex_valid_o}, 32'd0);
      check("mid_rst_instr", ex_instr_o, 32'd0);
      check("mid_rst_pc",    ex_pc_o, 32'd0);
      check("mid_rst_rd_we", {31'b0, ex_rd_we_o}, 32'd0);
      check("mid_rst_busy",  {31'b0, busy_o}, 32'd0);
      check("mid_rst_err",   {31'b0, sb_err_o}, 32'd0);
      reset_model();
      idle();
      @(posedge clk_i);
      #1 rst_ni = 1;

      // random traffic on a small register window to provoke hazards
      for (int n = 0; n < 400; n++) begin
         int r;
         if_valid_i = ($urandom_range(0, 3) != 0);
         instr_i    = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
         instr_i[31:25] = 7'($urandom);
         pc_i       = $urandom;
         rs1_used_i = $urandom_range(0, 1);
         rs2_used_i = $urandom_range(0, 1);
         rd_we_i    = $urandom_range(0, 1);
         ex_ready_i = ($urandom_range(0, 3) != 0);
         flush_i    = ($urandom_range(0, 19) == 0);
         rel_valid_i = 0;
         rel_addr_i  = '0;
         if ($urandom_range(0, 99) < 35) begin
            r = $urandom_range(0, 7);
            if (cnt_m[r] > 0 || $urandom_range(0, 9) == 0) release_reg(r);
         end
         cycle();
      end
      idle();
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
